// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the Pmod KYPD scanner.
//  - Key-code constants for the operator keys.
//  - Frame-result encoding: 5 bits {valid, code}; KEY_NONE means "no single key".
//  - Scan FSM state type, column drive helper and the key-map decoder.
package keypad_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [4:0] KEY_NONE = 5'b0_0000;

  // Column index 0 is the left column (Col[3]), index 3 the right column (Col[0]).
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } scan_state_t;

  // Active-low column drive: exactly one bit low, left column first.
  function automatic logic [3:0] col_drive(input logic [1:0] col_idx);
    logic [3:0] lead;
    lead = 4'b1000;
    return ~(lead >> col_idx);
  endfunction

  // row_onehot is active-high with bit 3 = top row. Anything that is not
  // exactly one row decodes to KEY_NONE.
  function automatic logic [4:0] decode_key(input logic [1:0] col_idx,
                                            input logic [3:0] row_onehot);
    logic [1:0] row_idx;
    logic [3:0] code;
    logic       valid;
    valid   = 1'b1;
    row_idx = 2'd0;
    code    = 4'h0;
    case (row_onehot)
      4'b1000: row_idx = 2'd0;
      4'b0100: row_idx = 2'd1;
      4'b0010: row_idx = 2'd2;
      4'b0001: row_idx = 2'd3;
      default: valid = 1'b0;
    endcase
    case ({row_idx, col_idx})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = KEY_ADD;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = KEY_SUB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = KEY_MUL;
      4'd12: code = 4'h0;
      4'd13: code = KEY_CLR;
      4'd14: code = KEY_EQ;
      4'd15: code = KEY_DIV;
      default: code = 4'h0;
    endcase
    return valid ? {1'b1, code} : KEY_NONE;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: commits a frame result once it has been seen on
// DEBOUNCE_SCANS consecutive frames and differs from what is committed.
// Ports:
//  clk, rst          clock, asynchronous active-high reset
//  frame_result [5]  {valid, code} of the frame just closed
//  frame_done        one-cycle pulse qualifying frame_result
//  key_code     [4]  last committed key code (held after release)
//  key_pressed       a debounced key is held
//  key_strobe        one-cycle pulse on each new key commit
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] frame_result,
  input  logic       frame_done,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       key_strobe
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [4:0]    prev_reg, prev_next;
  logic [CW-1:0] stable_cnt_reg, stable_cnt_next;
  logic [4:0]    committed_reg;
  logic [3:0]    code_reg;
  logic          pressed_reg;
  logic          strobe_reg;
  logic          commit;

  always_comb begin
    prev_next       = prev_reg;
    stable_cnt_next = stable_cnt_reg;
    if (frame_done) begin
      if (frame_result == prev_reg) begin
        if (stable_cnt_reg < CW'(DEBOUNCE_SCANS))
          stable_cnt_next = stable_cnt_reg + 1'b1;
      end else begin
        stable_cnt_next = CW'(1);
        prev_next       = frame_result;
      end
    end
  end

  // Comparing against the full committed {valid, code} means a held key never
  // re-commits, while a direct slide to another key does.
  assign commit = frame_done && (stable_cnt_next == CW'(DEBOUNCE_SCANS)) &&
                  (frame_result != committed_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg       <= KEY_NONE;
      stable_cnt_reg <= '0;
      committed_reg  <= KEY_NONE;
      code_reg       <= 4'h0;
      pressed_reg    <= 1'b0;
      strobe_reg     <= 1'b0;
    end else begin
      prev_reg       <= prev_next;
      stable_cnt_reg <= stable_cnt_next;
      strobe_reg     <= 1'b0;
      if (commit) begin
        committed_reg <= frame_result;
        if (frame_result[4]) begin
          code_reg    <= frame_result[3:0];
          pressed_reg <= 1'b1;
          strobe_reg  <= 1'b1;
        end else begin
          pressed_reg <= 1'b0;
        end
      end
    end
  end

  assign key_code    = code_reg;
  assign key_pressed = pressed_reg;
  assign key_strobe  = strobe_reg;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans the 4x4 Pmod KYPD and reports one debounced key.
// Ports:
//  clk, rst        100 MHz clock, asynchronous active-high reset
//  Row        [4]  keypad rows, active-low, Row[3] = top row
//  Col        [4]  keypad columns, one bit low, Col[3] = left column
//  DecodeOut  [4]  committed key code, held after release
//  KeyPressed      debounced key currently held
//  KeyStrobe       one-cycle pulse on each new committed key
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] DecodeOut,
  output logic       KeyPressed,
  output logic       KeyStrobe
);

  localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // Two-flop synchronizer per row; idle level is high (pulled up).
  logic [3:0] row_sync;

  for (genvar gi = 0; gi < 4; gi++) begin : g_row_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_reg <= 1'b1;
        sync_reg <= 1'b1;
      end else begin
        meta_reg <= Row[gi];
        sync_reg <= meta_reg;
      end
    end
    assign row_sync[gi] = sync_reg;
  end

  scan_state_t   state_reg;
  logic [3:0]    col_reg;
  logic [DW-1:0] dwell_reg;
  logic [1:0]    frame_cnt_reg, frame_cnt_next;   // low rows seen so far, saturates at 2
  logic [4:0]    frame_key_reg, frame_key_next;
  logic [4:0]    frame_result_reg;
  logic          frame_done_reg;

  logic [3:0]    rows_low;
  logic [2:0]    low_count;
  scan_state_t   state_next;

  assign rows_low   = ~row_sync;
  assign state_next = scan_state_t'(state_reg + 2'd1);

  // Fold this column's sample into the frame. Any second low row, whether in
  // the same column or another, marks the frame as ambiguous.
  always_comb begin
    low_count = 3'd0;
    for (int i = 0; i < 4; i++)
      low_count = low_count + {2'b00, rows_low[i]};
    frame_cnt_next = frame_cnt_reg;
    frame_key_next = frame_key_reg;
    if (low_count >= 3'd2) begin
      frame_cnt_next = 2'd2;
    end else if (low_count == 3'd1) begin
      if (frame_cnt_reg == 2'd0) begin
        frame_cnt_next = 2'd1;
        frame_key_next = decode_key(state_reg, rows_low);
      end else begin
        frame_cnt_next = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= COL0;
      col_reg          <= 4'b0111;
      dwell_reg        <= '0;
      frame_cnt_reg    <= 2'd0;
      frame_key_reg    <= KEY_NONE;
      frame_result_reg <= KEY_NONE;
      frame_done_reg   <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (dwell_reg == DW'(SETTLE_CYCLES - 1)) begin
        dwell_reg <= '0;
        state_reg <= state_next;
        col_reg   <= col_drive(state_next);
        if (state_reg == COL3) begin
          frame_result_reg <= (frame_cnt_next == 2'd1) ? frame_key_next : KEY_NONE;
          frame_done_reg   <= 1'b1;
          frame_cnt_reg    <= 2'd0;
          frame_key_reg    <= KEY_NONE;
        end else begin
          frame_cnt_reg <= frame_cnt_next;
          frame_key_reg <= frame_key_next;
        end
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end
    end
  end

  assign Col = col_reg;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .frame_result (frame_result_reg),
    .frame_done   (frame_done_reg),
    .key_code     (DecodeOut),
    .key_pressed  (KeyPressed),
    .key_strobe   (KeyStrobe)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 2;
  localparam int FRAME  = 4 * SETTLE;
  localparam int LAT    = (DEB + 1) * FRAME + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Row;
  logic [3:0] Col;
  logic [3:0] DecodeOut;
  logic       KeyPressed;
  logic       KeyStrobe;

  // press[r*4+c]: r = row from top, c = column from left
  logic [15:0] press = '0;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Row        (Row),
    .Col        (Col),
    .DecodeOut  (DecodeOut),
    .KeyPressed (KeyPressed),
    .KeyStrobe  (KeyStrobe)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its row to its column.
  always_comb begin
    Row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !Col[3-c]) Row[3-r] = 1'b0;
  end

  // Scoreboard: every strobe pops one expected code.
  always @(negedge clk) begin
    logic [3:0] want;
    if (!rst && KeyStrobe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got DecodeOut=%h, required no strobe", DecodeOut);
      end else begin
        want = exp_q.pop_front();
        if (DecodeOut !== want || KeyPressed !== 1'b1) begin
          failures++;
          $display("FAIL strobe_code: got DecodeOut=%h KeyPressed=%b, required %h/1", DecodeOut, KeyPressed, want);
        end else begin
          $display("strobe DecodeOut=%h expected=%h", DecodeOut, want);
        end
      end
    end
  end

  task automatic wait_strobe(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic wait_release(input int max_cycles);
    int n = 0;
    @(negedge clk);
    while (KeyPressed && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [3:0] lead;
    logic [3:0] want;
    lead = 4'b1000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (Col !== 4'b0111 || DecodeOut !== 4'h0 || KeyPressed !== 1'b0 || KeyStrobe !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got Col=%b Dec=%h KP=%b KS=%b, required 0111/0/0/0", Col, DecodeOut, KeyPressed, KeyStrobe);
    end
    @(negedge clk) rst = 1'b0;
    checks++;
    if (Col !== 4'b0111) begin
      failures++;
      $display("FAIL reset_release_col: got %b, required 0111", Col);
    end
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      want = ~(lead >> ((k / 4) % 4));
      checks++;
      if (Col !== want) begin
        failures++;
        $display("FAIL col_walk: cycle %0d got %b, required %b", k, Col, want);
      end
    end
    $display("reset and column walk done");
  endtask

  task automatic test_press_release();
    @(posedge clk); #1;
    press[1*4+1] = 1'b1;
    exp_q.push_back(4'h5);
    wait_strobe(LAT);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL press5_timeout: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3 * FRAME) @(negedge clk);
    checks++;
    if (DecodeOut !== 4'h5 || KeyPressed !== 1'b1) begin
      failures++;
      $display("FAIL press5_hold: got Dec=%h KP=%b, required 5/1", DecodeOut, KeyPressed);
    end
    press = '0;
    wait_release(LAT);
    checks++;
    if (KeyPressed !== 1'b0 || DecodeOut !== 4'h5) begin
      failures++;
      $display("FAIL release5: got KP=%b Dec=%h, required 0/5", KeyPressed, DecodeOut);
    end
    $display("press/release of 5 done");
  endtask

  task automatic test_keys();
    int         kidx[3];
    logic [3:0] kcode[3];
    kidx[0] = 3*4+3; kcode[0] = 4'hD;
    kidx[1] = 0*4+3; kcode[1] = 4'hA;
    kidx[2] = 3*4+0; kcode[2] = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      press = '0;
      press[kidx[i]] = 1'b1;
      exp_q.push_back(kcode[i]);
      wait_strobe(LAT);
      checks++;
      if (exp_q.size() != 0 || DecodeOut !== kcode[i]) begin
        failures++;
        $display("FAIL key_%h: got Dec=%h pending=%0d, required %h/0", kcode[i], DecodeOut, exp_q.size(), kcode[i]);
        exp_q.delete();
      end
      press = '0;
      wait_release(LAT);
      checks++;
      if (KeyPressed !== 1'b0) begin
        failures++;
        $display("FAIL key_%h_release: got KP=%b, required 0", kcode[i], KeyPressed);
      end
    end
    $display("corner keys done");
  endtask

  task automatic test_bounce();
    bit saw;
    for (int f = 0; f < 6; f++) begin
      @(posedge clk); #1;
      press[2*4+0] = ~press[2*4+0];
      saw = 1'b0;
      repeat (FRAME - 1) begin
        @(negedge clk);
        if (KeyPressed) saw = 1'b1;
      end
      checks++;
      if (saw) begin
        failures++;
        $display("FAIL bounce7: frame %0d got KP=1, required 0", f);
      end
    end
    press = '0;
    repeat (3 * FRAME) @(negedge clk);
    checks++;
    if (KeyPressed !== 1'b0) begin
      failures++;
      $display("FAIL bounce7_after: got KP=%b, required 0", KeyPressed);
    end
    $display("bounce rejection done");
  endtask

  task automatic test_ghost();
    bit saw;
    @(posedge clk); #1;
    press[0] = 1'b1;
    press[1] = 1'b1;
    saw = 1'b0;
    repeat (5 * FRAME) begin
      @(negedge clk);
      if (KeyPressed) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL ghost12: got KP=1, required 0");
    end
    @(posedge clk); #1;
    press[1] = 1'b0;
    exp_q.push_back(4'h1);
    wait_strobe(LAT);
    checks++;
    if (exp_q.size() != 0 || DecodeOut !== 4'h1) begin
      failures++;
      $display("FAIL ghost_release2: got Dec=%h pending=%0d, required 1/0", DecodeOut, exp_q.size());
      exp_q.delete();
    end
    press = '0;
    wait_release(LAT);
    $display("multi-press rejection done");
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    press = '0;
    press[3*4+2] = 1'b1;
    exp_q.push_back(4'hE);
    repeat (20 * FRAME) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || DecodeOut !== 4'hE || KeyPressed !== 1'b1) begin
      failures++;
      $display("FAIL holdE: got Dec=%h KP=%b pending=%0d, required E/1/0", DecodeOut, KeyPressed, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
    press[3*4+2] = 1'b0;
    press[3*4+1] = 1'b1;
    exp_q.push_back(4'hF);
    wait_strobe(LAT);
    checks++;
    if (exp_q.size() != 0 || DecodeOut !== 4'hF || KeyPressed !== 1'b1) begin
      failures++;
      $display("FAIL slideF: got Dec=%h KP=%b pending=%0d, required F/1/0", DecodeOut, KeyPressed, exp_q.size());
      exp_q.delete();
    end
    press = '0;
    wait_release(LAT);
    checks++;
    if (KeyPressed !== 1'b0 || DecodeOut !== 4'hF) begin
      failures++;
      $display("FAIL releaseF: got KP=%b Dec=%h, required 0/F", KeyPressed, DecodeOut);
    end
    $display("hold and slide done");
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_keys();
    test_bounce();
    test_ghost();
    test_back_to_back();
    repeat (2 * FRAME) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
